scene_sequencer: RTL and testbench

SCENE_SEQUENCER -- requirements
Module: scene_sequencer

---
 rtl/scene_sequencer.sv | 133 +++++++++++++
 tb/tb_scene_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scene_sequencer.sv
// Scene sequencer: turns v_sync into a frame strobe, runs a free-running
// animation counter, and steps four scenes through fade-in, hold and fade-out.
module scene_sequencer #(
  parameter int HOLD_FRAMES = 240,
  parameter int FADE_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic       pause,
  input  logic       skip,
  output logic       frame_tick,
  output logic [9:0] anim_ctr,
  output logic [1:0] scene,
  output logic [2:0] layer_en,
  output logic [1:0] fade
);

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    HOLD     = 2'd1,
    FADE_OUT = 2'd2
  } state_t;

  localparam logic [9:0] HOLD_LAST = 10'(HOLD_FRAMES - 1);
  localparam logic [9:0] FADE_LAST = 10'(FADE_FRAMES - 1);

  state_t     state_q, state_d;
  logic [9:0] fcnt_q, fcnt_d;
  logic [1:0] fade_d;
  logic [1:0] scene_d;
  logic       vs_q;
  logic       eff_tick;

  assign eff_tick = frame_tick & ~pause;

  // vs_q resets high so a v_sync already asserted at reset release is not
  // mistaken for a new frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b1;
      frame_tick <= 1'b0;
      anim_ctr   <= '0;
    end else begin
      vs_q       <= v_sync;
      frame_tick <= v_sync & ~vs_q;
      if (eff_tick) anim_ctr <= anim_ctr + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FADE_IN;
      fcnt_q  <= '0;
      fade    <= 2'd0;
      scene   <= 2'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      fade    <= fade_d;
      scene   <= scene_d;
    end
  end

  // NOTE: every next-state signal gets a hold default before any branch,
  // so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    fade_d  = fade;
    scene_d = scene;

    if (skip && state_q != FADE_OUT) begin
      // Abandon the scene; skip wins over any coincident tick and ignores pause.
      state_d = FADE_OUT;
      fcnt_d  = '0;
    end else if (eff_tick) begin
      unique case (state_q)
        FADE_IN: begin
          if (fcnt_q == FADE_LAST) begin
            fcnt_d = '0;
            fade_d = fade + 2'd1;
            if (fade == 2'd2) state_d = HOLD;
          end else begin
            fcnt_d = fcnt_q + 10'd1;
          end
        end
        HOLD: begin
          if (fcnt_q == HOLD_LAST) begin
            fcnt_d  = '0;
            state_d = FADE_OUT;
          end else begin
            fcnt_d = fcnt_q + 10'd1;
          end
        end
        FADE_OUT: begin
          if (fcnt_q == FADE_LAST) begin
            fcnt_d = '0;
            // A skip taken at fade=0 must not underflow to full brightness.
            if (fade <= 2'd1) begin
              fade_d  = 2'd0;
              scene_d = scene + 2'd1;
              state_d = FADE_IN;
            end else begin
              fade_d = fade - 2'd1;
            end
          end else begin
            fcnt_d = fcnt_q + 10'd1;
          end
        end
        default: begin
          state_d = FADE_IN;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  // Layer order is {overlay, sine, sine_bg}.
  always_comb begin
    layer_en = 3'b011;
    unique case (scene)
      2'd0: layer_en = 3'b011;
      2'd1: layer_en = 3'b001;
      2'd2: layer_en = 3'b111;
      2'd3: layer_en = 3'b110;
      default: layer_en = 3'b011;
    endcase
  end

endmodule

// File: tb/tb_scene_sequencer.sv
// Directed bench for scene_sequencer with HOLD_FRAMES=4, FADE_FRAMES=2:
// a scene lasts 16 effective ticks (6 fade-in, 4 hold, 6 fade-out).
module tb_scene_sequencer;

  logic       clk;
  logic       rst_n;
  logic       v_sync;
  logic       pause;
  logic       skip;
  logic       frame_tick;
  logic [9:0] anim_ctr;
  logic [1:0] scene;
  logic [2:0] layer_en;
  logic [1:0] fade;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;
  int glitch_cnt = 0;
  logic tick_prev = 1'b0;

  scene_sequencer #(.HOLD_FRAMES(4), .FADE_FRAMES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .v_sync    (v_sync),
    .pause     (pause),
    .skip      (skip),
    .frame_tick(frame_tick),
    .anim_ctr  (anim_ctr),
    .scene     (scene),
    .layer_en  (layer_en),
    .fade      (fade)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: counts pulses and any strobe wider than one cycle.
  always @(negedge clk) begin
    if (frame_tick === 1'b1) tick_cnt++;
    if (frame_tick === 1'b1 && tick_prev === 1'b1) glitch_cnt++;
    tick_prev = frame_tick;
  end

  // One v_sync pulse (2 cycles high, 2 low); the tick is fully absorbed on return.
  task automatic pulse();
    @(negedge clk); v_sync = 1'b1;
    @(negedge clk);
    @(negedge clk); v_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic check_state(input string name, input logic [1:0] exp_fade,
                             input logic [1:0] exp_scene, input logic [9:0] exp_anim);
    // Used only to keep repeated triple comparisons compact per scenario.
    checks++;
    if (fade !== exp_fade) begin
      errors++;
      $display("FAIL %s fade: got %0d want %0d", name, fade, exp_fade);
    end
    checks++;
    if (scene !== exp_scene) begin
      errors++;
      $display("FAIL %s scene: got %0d want %0d", name, scene, exp_scene);
    end
    checks++;
    if (anim_ctr !== exp_anim) begin
      errors++;
      $display("FAIL %s anim_ctr: got %0d want %0d", name, anim_ctr, exp_anim);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int t0;
    v_sync = 1'b1; pause = 1'b0; skip = 1'b0; rst_n = 1'b0;
    #12;
    check_state("reset", 2'd0, 2'd0, 10'd0);
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset frame_tick: got %b want 0", frame_tick);
    end
    checks++;
    if (layer_en !== 3'b011) begin
      errors++;
      $display("FAIL reset layer_en: got %b want 011", layer_en);
    end
    // Release with v_sync already high: no strobe may appear.
    @(negedge clk);
    t0 = tick_cnt;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (tick_cnt - t0 != 0) begin
      errors++;
      $display("FAIL reset_release_vsync_high ticks: got %0d want 0", tick_cnt - t0);
    end
    v_sync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fade_in();
    logic [1:0] exp_fade [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    int t0;
    t0 = tick_cnt;
    for (int i = 0; i < 6; i++) begin
      pulse();
      check_state($sformatf("fade_in tick%0d", i + 1), exp_fade[i], 2'd0, 10'(i + 1));
    end
    checks++;
    if (tick_cnt - t0 != 6) begin
      errors++;
      $display("FAIL fade_in tick_count: got %0d want 6", tick_cnt - t0);
    end
  endtask

  // Enters with HOLD fcnt=0 after tick 6; pauses mid-hold, then finishes scene 0.
  task automatic test_pause();
    int t0;
    pulses(2);
    check_state("hold tick8", 2'd3, 2'd0, 10'd8);
    pause = 1'b1;
    t0 = tick_cnt;
    pulses(5);
    pause = 1'b0;
    checks++;
    if (tick_cnt - t0 != 5) begin
      errors++;
      $display("FAIL pause tick_count: got %0d want 5", tick_cnt - t0);
    end
    check_state("paused", 2'd3, 2'd0, 10'd8);
    pulses(2);
    check_state("resume tick10", 2'd3, 2'd0, 10'd10);
    pulses(2);
    check_state("resume tick12", 2'd2, 2'd0, 10'd12);
    pulses(4);
    check_state("scene1 tick16", 2'd0, 2'd1, 10'd16);
    checks++;
    if (layer_en !== 3'b001) begin
      errors++;
      $display("FAIL scene1 layer_en: got %b want 001", layer_en);
    end
  endtask

  task automatic test_scene_wrap();
    logic [2:0] exp_layer [3] = '{3'b111, 3'b110, 3'b011};
    for (int s = 0; s < 3; s++) begin
      pulses(16);
      check_state($sformatf("scene_wrap %0d", s), 2'd0, 2'(s + 2), 10'(32 + 16 * s));
      checks++;
      if (layer_en !== exp_layer[s]) begin
        errors++;
        $display("FAIL scene_wrap %0d layer_en: got %b want %b", s, layer_en, exp_layer[s]);
      end
    end
  endtask

  // Enters at scene 0, FADE_IN, fcnt=0, anim=64.
  task automatic test_skip();
    pulses(7);
    check_state("pre_skip hold", 2'd3, 2'd0, 10'd71);
    // skip held for the cycle frame_tick is high
    @(negedge clk); v_sync = 1'b1;
    @(negedge clk); skip = 1'b1;
    @(negedge clk); skip = 1'b0; v_sync = 1'b0;
    check_state("skip edge", 2'd3, 2'd0, 10'd72);
    @(negedge clk); @(negedge clk);
    pulse();
    check_state("skip +1", 2'd3, 2'd0, 10'd73);
    pulse();
    check_state("skip +2", 2'd2, 2'd0, 10'd74);
    // skip in FADE_OUT with fcnt=1 must be ignored
    pulse();
    @(negedge clk); skip = 1'b1;
    @(negedge clk); skip = 1'b0;
    pulse();
    check_state("skip in fade_out", 2'd1, 2'd0, 10'd76);
    pulses(2);
    check_state("skip scene end", 2'd0, 2'd1, 10'd78);
  endtask

  task automatic test_skip_paused();
    pulses(2);
    check_state("skip_paused pre", 2'd1, 2'd1, 10'd80);
    pause = 1'b1;
    @(negedge clk); skip = 1'b1;
    @(negedge clk); skip = 1'b0;
    pause = 1'b0;
    pulses(2);
    check_state("skip_paused post", 2'd0, 2'd2, 10'd82);
  endtask

  task automatic test_anim_wrap();
    int t0;
    int g0;
    t0 = tick_cnt;
    g0 = glitch_cnt;
    pulses(941);
    checks++;
    if (anim_ctr !== 10'd1023) begin
      errors++;
      $display("FAIL anim_wrap pre: got %0d want 1023", anim_ctr);
    end
    pulse();
    checks++;
    if (anim_ctr !== 10'd0) begin
      errors++;
      $display("FAIL anim_wrap: got %0d want 0", anim_ctr);
    end
    pulses(82);
    checks++;
    if (anim_ctr !== 10'd82) begin
      errors++;
      $display("FAIL anim_wrap post: got %0d want 82", anim_ctr);
    end
    checks++;
    if (tick_cnt - t0 != 1024) begin
      errors++;
      $display("FAIL anim_wrap tick_count: got %0d want 1024", tick_cnt - t0);
    end
    checks++;
    if (glitch_cnt - g0 != 0) begin
      errors++;
      $display("FAIL anim_wrap wide_strobe: got %0d want 0", glitch_cnt - g0);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    do_reset();
    pulses(44);
    check_state("mid pre_reset", 2'd2, 2'd2, 10'd44);
    @(negedge clk); v_sync = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_state("mid async", 2'd0, 2'd0, 10'd0);
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL mid async frame_tick: got %b want 0", frame_tick);
    end
    checks++;
    if (layer_en !== 3'b011) begin
      errors++;
      $display("FAIL mid async layer_en: got %b want 011", layer_en);
    end
    @(negedge clk); @(negedge clk);
    t0 = tick_cnt;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (tick_cnt - t0 != 0) begin
      errors++;
      $display("FAIL mid release ticks: got %0d want 0", tick_cnt - t0);
    end
    v_sync = 1'b0;
    repeat (2) @(negedge clk);
    pulse();
    checks++;
    if (tick_cnt - t0 != 1) begin
      errors++;
      $display("FAIL mid next_edge ticks: got %0d want 1", tick_cnt - t0);
    end
    check_state("mid after", 2'd0, 2'd0, 10'd1);
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_pause();
    test_scene_wrap();
    test_skip();
    test_skip_paused();
    test_anim_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
